// File: rtl/sobel_gcd_spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : sobel_gcd_spi_slave
// Brief    : Mode-0 SPI slave and register bank for the GCD and Sobel cores.
// Revision : 1.0  initial release
// ============================================================================
module sobel_gcd_spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       spi_sck_i,
  input  logic       spi_sdi_i,
  input  logic       spi_cs_i,
  output logic       spi_sdo_o,
  output logic [7:0] operand_a_o,
  output logic [7:0] operand_b_o,
  output logic       gcd_enable_o,
  output logic       prep_allowed_o,
  output logic [7:0] input_px_gray_o,
  output logic       px_valid_o,
  input  logic [7:0] gcd_i,
  input  logic       gcd_done_i,
  input  logic [7:0] output_px_sobel_i,
  input  logic       pixel_completed_i,
  input  logic       prep_completed_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WDATA = 2'd2,
    ST_RDATA = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sck_sync, r_sdi_sync, r_cs_sync;
  logic                   r_sck_q, r_cs_q;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic [6:0]             r_addr;
  logic                   r_load;
  logic                   r_sdo;
  logic [7:0]             r_operand_a, r_operand_b, r_px_gray;
  logic                   r_prep_allowed, r_gcd_en, r_px_valid;
  logic [2:0]             r_sticky;
  logic [7:0]             w_rd_data;

  // Synchronizers are left out of reset so they keep tracking the pins;
  // a reset mid-frame then produces no spurious CS edge.
  always_ff @(posedge clk_i) begin
    r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck_i};
    r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], spi_sdi_i};
    r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_i};
    r_sck_q    <= r_sck_sync[SYNC_STAGES-1];
    r_cs_q     <= r_cs_sync[SYNC_STAGES-1];
  end

  logic       w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall, w_sdi, w_byte_done;
  logic [7:0] w_shift_in;
  logic       w_status_clr;

  assign w_sck_rise  = r_sck_sync[SYNC_STAGES-1] & ~r_sck_q;
  assign w_sck_fall  = ~r_sck_sync[SYNC_STAGES-1] & r_sck_q;
  assign w_cs_rise   = r_cs_sync[SYNC_STAGES-1] & ~r_cs_q;
  assign w_cs_fall   = ~r_cs_sync[SYNC_STAGES-1] & r_cs_q;
  assign w_sdi       = r_sdi_sync[SYNC_STAGES-1];
  assign w_byte_done = w_sck_rise & (r_bit_cnt == 3'd7);
  assign w_shift_in  = {r_shift[6:0], w_sdi};
  assign w_status_clr = (r_state == ST_RDATA) & w_byte_done & (r_addr == 7'h12) & ~w_cs_rise;

  always_comb begin
    w_rd_data = 8'h00;
    case (r_addr)
      7'h00:   w_rd_data = r_operand_a;
      7'h01:   w_rd_data = r_operand_b;
      7'h02:   w_rd_data = {6'b0, r_prep_allowed, 1'b0};
      7'h03:   w_rd_data = r_px_gray;
      7'h10:   w_rd_data = gcd_i;
      7'h11:   w_rd_data = output_px_sobel_i;
      7'h12:   w_rd_data = {5'b0, r_sticky};
      default: w_rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_cs_rise) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_cs_fall) w_state_nxt = ST_CMD;
        ST_CMD:  if (w_byte_done) w_state_nxt = r_shift[6] ? ST_WDATA : ST_RDATA;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_bit_cnt      <= 3'd0;
      r_shift        <= 8'h00;
      r_addr         <= 7'h00;
      r_load         <= 1'b0;
      r_sdo          <= 1'b0;
      r_operand_a    <= 8'h00;
      r_operand_b    <= 8'h00;
      r_px_gray      <= 8'h00;
      r_prep_allowed <= 1'b0;
      r_gcd_en       <= 1'b0;
      r_px_valid     <= 1'b0;
    end else begin
      r_gcd_en   <= 1'b0;
      r_px_valid <= 1'b0;
      r_load     <= 1'b0;
      if (w_cs_rise || (r_state == ST_IDLE && w_cs_fall)) begin
        r_bit_cnt <= 3'd0;
        r_sdo     <= 1'b0;
      end else begin
        case (r_state)
          ST_CMD: begin
            if (w_sck_rise) begin
              r_shift   <= w_shift_in;
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_byte_done) begin
              r_addr <= w_shift_in[6:0];
              r_load <= ~r_shift[6];
            end
            if (w_sck_fall) r_sdo <= 1'b0;
          end
          ST_WDATA: begin
            if (w_sck_rise) begin
              r_shift   <= w_shift_in;
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_byte_done) begin
              r_addr <= r_addr + 7'd1;
              case (r_addr)
                7'h00: r_operand_a <= w_shift_in;
                7'h01: r_operand_b <= w_shift_in;
                7'h02: begin
                  r_prep_allowed <= w_shift_in[1];
                  r_gcd_en       <= w_shift_in[0];
                end
                7'h03: begin
                  r_px_gray  <= w_shift_in;
                  r_px_valid <= 1'b1;
                end
                default: ;
              endcase
            end
          end
          ST_RDATA: begin
            // Snapshot one cycle after the byte boundary, well before the next SCK fall.
            if (r_load) begin
              r_shift <= w_rd_data;
            end else if (w_sck_fall) begin
              r_sdo   <= r_shift[7];
              r_shift <= {r_shift[6:0], 1'b0};
            end
            if (w_sck_rise) r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_byte_done) begin
              r_addr <= r_addr + 7'd1;
              r_load <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Set has priority over the read-side clear.
  always_ff @(posedge clk_i) begin
    if (reset_i) r_sticky <= 3'b000;
    else r_sticky <= (r_sticky & ~{3{w_status_clr}}) |
                     {prep_completed_i, pixel_completed_i, gcd_done_i};
  end

  assign spi_sdo_o       = r_sdo;
  assign operand_a_o     = r_operand_a;
  assign operand_b_o     = r_operand_b;
  assign gcd_enable_o    = r_gcd_en;
  assign prep_allowed_o  = r_prep_allowed;
  assign input_px_gray_o = r_px_gray;
  assign px_valid_o      = r_px_valid;

endmodule
`default_nettype wire

// File: tb/tb_sobel_gcd_spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_gcd_spi_slave
// Brief    : Directed bench with a read-data scoreboard for sobel_gcd_spi_slave.
// Revision : 1.0  initial release
// ============================================================================
module tb_sobel_gcd_spi_slave;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 8;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       spi_sck_i = 1'b0, spi_sdi_i = 1'b0, spi_cs_i = 1'b1;
  logic       spi_sdo_o;
  logic [7:0] operand_a_o, operand_b_o, input_px_gray_o;
  logic       gcd_enable_o, prep_allowed_o, px_valid_o;
  logic [7:0] gcd_i = 8'h00, output_px_sobel_i = 8'h00;
  logic       gcd_done_i = 1'b0, pixel_completed_i = 1'b0, prep_completed_i = 1'b0;

  int         vectors = 0;
  int         miscompares = 0;
  int         gcd_en_cnt = 0;
  int         px_cnt = 0;
  logic [7:0] px_seen = 8'h00;
  logic [7:0] exp_q[$];

  sobel_gcd_spi_slave #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .spi_sck_i(spi_sck_i), .spi_sdi_i(spi_sdi_i), .spi_cs_i(spi_cs_i),
    .spi_sdo_o(spi_sdo_o),
    .operand_a_o(operand_a_o), .operand_b_o(operand_b_o),
    .gcd_enable_o(gcd_enable_o), .prep_allowed_o(prep_allowed_o),
    .input_px_gray_o(input_px_gray_o), .px_valid_o(px_valid_o),
    .gcd_i(gcd_i), .gcd_done_i(gcd_done_i),
    .output_px_sobel_i(output_px_sobel_i),
    .pixel_completed_i(pixel_completed_i), .prep_completed_i(prep_completed_i)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (gcd_enable_o) gcd_en_cnt++;
    if (px_valid_o) begin
      px_cnt++;
      px_seen = input_px_gray_o;
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Optionally pulses gcd_done_i exactly on the cycle the last rise is seen.
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, input bit pulse_last,
                          output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_sdi_i = tx[i];
      tick(HALF);
      rx[i] = spi_sdo_o;
      spi_sck_i = 1'b1;
      if (pulse_last && i == 0) begin
        tick(SYNC_STAGES);
        gcd_done_i = 1'b1;
        tick(1);
        gcd_done_i = 1'b0;
        tick(HALF - SYNC_STAGES - 1);
      end else begin
        tick(HALF);
      end
      spi_sck_i = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs_i = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_high();
    tick(HALF);
    spi_cs_i = 1'b1;
    tick(HALF);
  endtask

  task automatic write_frame(input logic [6:0] addr, input int n, input logic [23:0] data);
    logic [7:0] rx;
    cs_low();
    spi_xfer({1'b1, addr}, 8, 1'b0, rx);
    for (int k = 0; k < n; k++) spi_xfer(data[23-8*k -: 8], 8, 1'b0, rx);
    cs_high();
  endtask

  task automatic read_frame(input logic [6:0] addr, input int n, input bit pulse_last);
    logic [7:0] rx;
    cs_low();
    spi_xfer({1'b0, addr}, 8, 1'b0, rx);
    check("sdo_during_cmd", rx, 8'h00);
    for (int k = 0; k < n; k++) begin
      spi_xfer(8'h00, 8, pulse_last && (k == n - 1), rx);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL sb_underflow observed=0x%02h expected=none", rx);
      end else begin
        check("read_data", rx, exp_q.pop_front());
      end
    end
    cs_high();
  endtask

  task automatic pulse(input bit g, input bit p, input bit q);
    gcd_done_i = g; pixel_completed_i = p; prep_completed_i = q;
    tick(1);
    gcd_done_i = 1'b0; pixel_completed_i = 1'b0; prep_completed_i = 1'b0;
    tick(2);
  endtask

  initial begin
    logic [7:0] rx;
    tick(6);
    reset_i = 1'b0;
    tick(2);
    check("rst_operand_a", operand_a_o, 8'h00);
    check("rst_operand_b", operand_b_o, 8'h00);
    check("rst_px_gray", input_px_gray_o, 8'h00);
    check("rst_prep", {7'b0, prep_allowed_o}, 8'h00);
    check("rst_sdo", {7'b0, spi_sdo_o}, 8'h00);

    // Write burst with auto-increment.
    write_frame(7'h00, 2, 24'h241800);
    check("burst_a", operand_a_o, 8'h24);
    check("burst_b", operand_b_o, 8'h18);
    check("burst_no_gcd_pulse", 8'(gcd_en_cnt), 8'd0);
    check("burst_no_px_pulse", 8'(px_cnt), 8'd0);

    // Control register.
    write_frame(7'h02, 1, 24'h030000);
    check("ctrl_gcd_pulse_cycles", 8'(gcd_en_cnt), 8'd1);
    check("ctrl_prep", {7'b0, prep_allowed_o}, 8'h01);
    exp_q.push_back(8'h02);
    read_frame(7'h02, 1, 1'b0);

    // Pixel stream: only address 0x03 is mapped.
    write_frame(7'h03, 3, 24'h556677);
    check("px_pulse_count", 8'(px_cnt), 8'd1);
    check("px_value_at_pulse", px_seen, 8'h55);
    check("px_gray", input_px_gray_o, 8'h55);
    check("px_gcd_pulses", 8'(gcd_en_cnt), 8'd1);
    exp_q.push_back(8'h24); exp_q.push_back(8'h18);
    exp_q.push_back(8'h02); exp_q.push_back(8'h55);
    read_frame(7'h00, 4, 1'b0);

    // Core results and address wrap.
    gcd_i = 8'h06; output_px_sobel_i = 8'hA5;
    exp_q.push_back(8'h06); exp_q.push_back(8'hA5);
    read_frame(7'h10, 2, 1'b0);
    exp_q.push_back(8'h00); exp_q.push_back(8'h24);
    read_frame(7'h7F, 2, 1'b0);

    // Sticky status.
    pulse(1'b1, 1'b0, 1'b0);
    exp_q.push_back(8'h01);
    read_frame(7'h12, 1, 1'b0);
    exp_q.push_back(8'h00);
    read_frame(7'h12, 1, 1'b0);
    exp_q.push_back(8'h00);
    read_frame(7'h12, 1, 1'b1);
    exp_q.push_back(8'h01);
    read_frame(7'h12, 1, 1'b0);
    exp_q.push_back(8'h00);
    read_frame(7'h12, 1, 1'b0);
    pulse(1'b0, 1'b1, 1'b1);
    exp_q.push_back(8'h06);
    read_frame(7'h12, 1, 1'b0);

    // Abort after 5 data bits.
    cs_low();
    spi_xfer(8'h80, 8, 1'b0, rx);
    spi_xfer(8'hFF, 5, 1'b0, rx);
    cs_high();
    check("abort_a_unchanged", operand_a_o, 8'h24);
    check("abort_sdo", {7'b0, spi_sdo_o}, 8'h00);
    write_frame(7'h00, 1, 24'h5A0000);
    check("after_abort_a", operand_a_o, 8'h5A);
    check("after_abort_b", operand_b_o, 8'h18);

    // Reset mid-frame: the remainder of the frame must be ignored.
    cs_low();
    spi_xfer(8'h81, 8, 1'b0, rx);
    spi_xfer(8'hFF, 3, 1'b0, rx);
    reset_i = 1'b1;
    tick(3);
    reset_i = 1'b0;
    spi_xfer(8'hFF, 5, 1'b0, rx);
    spi_xfer(8'h81, 8, 1'b0, rx);
    spi_xfer(8'h99, 8, 1'b0, rx);
    cs_high();
    check("midrst_a", operand_a_o, 8'h00);
    check("midrst_b", operand_b_o, 8'h00);
    check("midrst_prep", {7'b0, prep_allowed_o}, 8'h00);
    check("sb_leftover", 8'(exp_q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sobel_gcd_spi_slave.md
# sobel_gcd_spi_slave

SPI slave and register bank that connects the external SPI pins to the GCD and Sobel cores. It synchronizes the asynchronous SPI pins into the system clock domain and decodes byte frames into register writes and reads. It drives operand, pixel and control registers into the cores and returns their results and sticky status over SDO.

## Interface
Parameters:
- SYNC_STAGES, 2: flip-flop depth of the pin synchronizers (≥2).

Ports:
- clk_i  in  1  system clock; one clock domain only.
- reset_i  in  1  synchronous, active-high reset.
- spi_sck_i  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous.
- spi_sdi_i  in  1  SPI data in, MSB first.
- spi_cs_i  in  1  chip select, active low.
- spi_sdo_o  out  1  SPI data out, MSB first.
- operand_a_o  out  8  GCD operand A (reg 0x00).
- operand_b_o  out  8  GCD operand B (reg 0x01).
- gcd_enable_o  out  1  one-cycle pulse on a write of reg 0x02 with bit0=1.
- prep_allowed_o  out  1  level, reg 0x02 bit1.
- input_px_gray_o  out  8  grayscale pixel to Sobel (reg 0x03).
- px_valid_o  out  1  one-cycle pulse on each write of reg 0x03.
- gcd_i  in  8  GCD result (read at 0x10).
- gcd_done_i  in  1  pulse from the GCD core.
- output_px_sobel_i  in  8  Sobel result (read at 0x11).
- pixel_completed_i  in  1  pulse from the Sobel core.
- prep_completed_i  in  1  pulse from the Sobel core.

## Operation
- Pins are passed through SYNC_STAGES flops, then one edge-detect flop. The block sees an SCK rise or fall and a CS fall or rise as single-cycle events.
- Frame format: CS falls, then a command byte [7]=W(1)/R(0), [6:0]=address, then any number of data bytes.
- The address auto-increments after each data byte and wraps 0x7F→0x00.
- FSM states:
  - IDLE: CS falling → CMD, bit counter=0.
  - CMD: shift SDI on each SCK rise. After the 8th bit, go to WDATA if W=1, else RDATA.
  - WDATA: shift 8 bits, then commit to the addressed register and stay in WDATA for the next byte.
  - RDATA: at entry and after each 8th bit, load the shift register with the current address value.
- CS rising in any state → IDLE. A partial byte is discarded and nothing is committed. SDO returns to 0.
- Write map:
  - 0x00 → operand_a_o; 0x01 → operand_b_o; 0x03 → input_px_gray_o plus px_valid_o pulse.
  - 0x02: bit1 → prep_allowed_o; bit0=1 → gcd_enable_o pulse (bit0 is not stored).
  - Writes to any other address are ignored.
- Read map:
  - 0x00–0x03 read back the stored values (0x02 reads {6'b0, prep_allowed, 0}).
  - 0x10 = gcd_i; 0x11 = output_px_sobel_i.
  - 0x12 = status {5'b0, prep_done, pix_done, gcd_done}.
  - Any other address reads 0x00.
- Status bits are sticky. Each is set by its input pulse and cleared after the last bit of a 0x12 read byte is shifted. If a set and a clear occur in the same cycle, set wins.

## Timing
- Reset: all output registers 0, spi_sdo_o=0, sticky bits 0, FSM IDLE, counters 0.
- SCK frequency must be ≤ clk_i/8. Pin-to-event latency is SYNC_STAGES+1 cycles.
- Sampling: SDI is sampled in the cycle the SCK-rise event is seen.
- SDO drive:
  - SDO updates in the cycle an SCK-fall event is seen.
  - The first data MSB is driven on the SCK fall that follows the 8th command rise.
  - SDO is 0 during the command byte.
- Write commit: the register updates, and any pulse output asserts for exactly 1 cycle, in the cycle after the 8th data-bit rise event.
- Read snapshot: a read value is captured in the cycle after the rise event that completes the previous byte. Later changes of gcd_i are not reflected until the next byte.
- Reset mid-frame: reset wins. The block returns to IDLE and ignores the rest of the frame until CS rises and falls again.

## Test plan
- Write burst: cmd 0x80, data 0x24, 0x18 → operand_a_o=0x24, operand_b_o=0x18. No pulses.
- Control: write 0x82 with data 0x03 → gcd_enable_o high for 1 cycle, prep_allowed_o=1. Read back 0x02 → 0x02.
- Pixel stream: cmd 0x83 with 3 data bytes → addresses 0x03, 0x04, 0x05. Only one px_valid_o pulse (at 0x03) with input_px_gray_o at its value; the rest are ignored.
- Read result: gcd_i=0x06, cmd 0x10 plus 2 dummy bytes → SDO returns 0x06 then output_px_sobel_i.
- Sticky status: pulse gcd_done_i, read 0x12 → 0x01; a second read → 0x00. A gcd_done_i pulse on the clear cycle → the next read is 0x01.
- Abort: CS rises after 5 data bits of a write to 0x00 → operand_a_o unchanged and FSM IDLE. The next full frame works normally.
